// File: rtl/tt_um_jleugeri_ticktocktokens_ioseq_pkg.sv
// Shared types for the token-network host I/O sequencer: FSM state encoding
// and bit positions of the core's start/stop pair.
package tt_um_jleugeri_ticktocktokens_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INJECT,
    TOCK,
    WAIT,
    COLLECT
  } ioseq_state_t;

  localparam int START_BIT = 0;
  localparam int STOP_BIT  = 1;

endpackage

// File: rtl/tt_um_jleugeri_ticktocktokens_ioseq_if.sv
// Sequencer <-> token-network core bus. The sequencer is master (drives hold,
// slow clock, tokens and processor id); the core answers with done/start-stop.
interface tt_um_jleugeri_ticktocktokens_ioseq_if #(
  parameter int TOKENS_BITS = 8,
  parameter int PID_BITS    = 4
);
  logic                   core_hold;
  logic                   core_clock_slow;
  logic [TOKENS_BITS-1:0] core_tokens_in;
  logic [PID_BITS-1:0]    core_processor_id;
  logic                   core_done;
  logic [1:0]             core_token_startstop;

  modport master (
    output core_hold, core_clock_slow, core_tokens_in, core_processor_id,
    input  core_done, core_token_startstop
  );

  modport slave (
    input  core_hold, core_clock_slow, core_tokens_in, core_processor_id,
    output core_done, core_token_startstop
  );
endinterface

// File: rtl/tt_um_jleugeri_ticktocktokens_ioseq_tickgen.sv
// Tick request generator: programmable divider while running, single-step
// otherwise, a one-deep pending flag and a sticky overrun flag.
module tt_um_jleugeri_ticktocktokens_tickgen #(
  parameter int DIV_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_en,
  input  logic                step,
  input  logic [DIV_BITS-1:0] div_value,
  input  logic                clr_flags,
  input  logic                take,
  output logic                tick_pending,
  output logic                overrun
);

  logic [DIV_BITS-1:0] div_cnt;
  logic                div_hit;
  logic                req;

  assign div_hit = (div_cnt == div_value);
  assign req     = run_en ? div_hit : step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (!run_en || div_hit) div_cnt <= '0;
      else                    div_cnt <= div_cnt + 1'b1;
      // A request landing in the same cycle as the FSM pickup re-arms pending.
      tick_pending <= req | (tick_pending & ~take);
      if (req && tick_pending) overrun <= 1'b1;
      else if (clr_flags)      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ticktocktokens_ioseq.sv
// Host-side I/O sequencer: inject -> tock -> wait done -> collect per tick.
// Optional macro TTT_IOSEQ_EVENT_COUNT_EN builds the saturating start-event counter.
module tt_um_jleugeri_ticktocktokens_ioseq
  import tt_um_jleugeri_ticktocktokens_pkg::*;
#(
  parameter int NUM_PROCESSORS = 10,
  parameter int TOKENS_BITS    = 8,
  parameter int DIV_BITS       = 8,
  parameter int TIMEOUT_BITS   = 8,
  parameter int PID_BITS       = $clog2(NUM_PROCESSORS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_en,
  input  logic                   step,
  input  logic [DIV_BITS-1:0]    div_value,
  input  logic                   clr_flags,
  input  logic                   inj_we,
  input  logic [PID_BITS-1:0]    inj_addr,
  input  logic [TOKENS_BITS-1:0] inj_data,
  input  logic [PID_BITS-1:0]    rd_addr,
  output logic [1:0]             rd_data,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout,
  output logic [7:0]             tick_count,
  output logic [15:0]            evt_count,
  tt_um_jleugeri_ticktocktokens_ioseq_if.master core
);

  localparam logic [PID_BITS-1:0]     LAST_PID  = PID_BITS'(NUM_PROCESSORS - 1);
  localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST = ~TIMEOUT_BITS'(1);

  ioseq_state_t           state;
  logic [PID_BITS-1:0]    pid;
  logic [PID_BITS-1:0]    inj_sel;
  logic [TOKENS_BITS-1:0] tokens;
  logic                   hold;
  logic                   slow;
  logic [TIMEOUT_BITS-1:0] wdog;
  logic                   tick_pending;
  logic                   take;
  logic                   load_inj;
  logic [TOKENS_BITS-1:0] inj [NUM_PROCESSORS];
  logic [1:0]             ss  [NUM_PROCESSORS];

  tt_um_jleugeri_ticktocktokens_tickgen #(.DIV_BITS(DIV_BITS)) u_tickgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .step         (step),
    .div_value    (div_value),
    .clr_flags    (clr_flags),
    .take         (take),
    .tick_pending (tick_pending),
    .overrun      (overrun)
  );

  // Token outputs are registered, so the bank is read one entry ahead of pid.
  assign take     = (state == IDLE) && tick_pending;
  assign load_inj = take || ((state == INJECT) && (pid != LAST_PID));
  assign inj_sel  = (state == IDLE) ? '0 : pid + 1'b1;
  assign busy     = (state != IDLE);

  assign core.core_hold         = hold;
  assign core.core_clock_slow   = slow;
  assign core.core_tokens_in    = tokens;
  assign core.core_processor_id = pid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) inj[i] <= '0;
    end else begin
      if (load_inj) inj[inj_sel] <= '0;
      // Host write issued after the clear so it survives to the next tick.
      if (inj_we && (inj_addr <= LAST_PID)) inj[inj_addr] <= inj_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= 1'b1;
      slow       <= 1'b0;
      tokens     <= '0;
      pid        <= '0;
      wdog       <= '0;
      timeout    <= 1'b0;
      tick_count <= '0;
    end else begin
      slow <= 1'b0;
      if (clr_flags) timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_pending) begin
            state  <= INJECT;
            hold   <= 1'b0;
            pid    <= '0;
            tokens <= inj[inj_sel];
          end
        end
        INJECT: begin
          if (pid == LAST_PID) begin
            state  <= TOCK;
            slow   <= 1'b1;
            tokens <= '0;
          end else begin
            pid    <= pid + 1'b1;
            tokens <= inj[inj_sel];
          end
        end
        TOCK: begin
          state <= WAIT;
          wdog  <= '0;
        end
        WAIT: begin
          wdog <= wdog + 1'b1;
          if (core.core_done || (wdog == WDOG_LAST)) begin
            if (!core.core_done) timeout <= 1'b1;
            state <= COLLECT;
            hold  <= 1'b1;
            pid   <= '0;
          end
        end
        COLLECT: begin
          if (pid == LAST_PID) begin
            state      <= IDLE;
            pid        <= '0;
            tick_count <= tick_count + 8'd1;
          end else begin
            pid <= pid + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) ss[i] <= 2'b00;
      rd_data <= 2'b00;
    end else begin
      rd_data <= (rd_addr <= LAST_PID) ? ss[rd_addr] : 2'b00;
      if (state == COLLECT)
        ss[pid] <= {core.core_token_startstop[STOP_BIT], core.core_token_startstop[START_BIT]};
    end
  end

`ifdef TTT_IOSEQ_EVENT_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [15:0] evt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)         evt_q <= '0;
    else if (clr_flags) evt_q <= '0;
    else if ((state == COLLECT) && core.core_token_startstop[START_BIT])
      evt_q <= sat_inc(evt_q);
  end

  assign evt_count = evt_q;
`else
  assign evt_count = '0;
`endif

endmodule

// File: tb/tb_tt_um_jleugeri_ticktocktokens_ioseq.sv
// Self-checking bench for the I/O sequencer with a transaction-level model
// of the injection/collect banks, tick counter and event counter.
module tb_tt_um_jleugeri_ticktocktokens_ioseq;
  localparam int NP = 10;
  localparam int TW = 8;
  localparam int DW = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, run_en, step, clr_flags, inj_we;
  logic [DW-1:0] div_value;
  logic [PW-1:0] inj_addr, rd_addr;
  logic [TW-1:0] inj_data;
  logic [1:0]    rd_data;
  logic          busy, overrun, timeout;
  logic [7:0]    tick_count;
  logic [15:0]   evt_count;

  tt_um_jleugeri_ticktocktokens_ioseq_if #(.TOKENS_BITS(TW), .PID_BITS(PW)) core_bus ();

  tt_um_jleugeri_ticktocktokens_ioseq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .step       (step),
    .div_value  (div_value),
    .clr_flags  (clr_flags),
    .inj_we     (inj_we),
    .inj_addr   (inj_addr),
    .inj_data   (inj_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout),
    .tick_count (tick_count),
    .evt_count  (evt_count),
    .core       (core_bus)
  );

  // Core stand-in: answers start/stop for whichever processor is addressed.
  logic [1:0] resp_tab [NP];
  assign core_bus.core_token_startstop =
    (core_bus.core_processor_id < PW'(NP)) ? resp_tab[core_bus.core_processor_id] : 2'b00;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TW-1:0] inj_m [NP];
  logic [1:0]    ss_m  [NP];
  int            tick_m;
  int            evt_m;

  logic [TW-1:0] obs_tok [NP];
  logic [TW-1:0] obs_tok_tock;
  logic          obs_slow, obs_idle_after;
  int            obs_seq_err, obs_wait;

  function automatic int evt_exp();
`ifdef TTT_IOSEQ_EVENT_COUNT_EN
    return evt_m;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin inj_m[i] = '0; ss_m[i] = 2'b00; end
    tick_m = 0;
    evt_m  = 0;
  endtask

  task automatic model_tick();
    for (int i = 0; i < NP; i++) begin
      if (resp_tab[i][0] && evt_m < 65535) evt_m++;
      ss_m[i]  = resp_tab[i];
      inj_m[i] = '0;
    end
    tick_m = (tick_m + 1) % 256;
  endtask

  task automatic randomize_resp();
    for (int i = 0; i < NP; i++) resp_tab[i] = 2'($urandom_range(3, 0));
  endtask

  task automatic write_inj(input int a, input logic [TW-1:0] d);
    inj_we = 1'b1; inj_addr = PW'(a); inj_data = d;
    @(negedge clk);
    inj_we = 1'b0;
    if (a < NP) inj_m[a] = d;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_busy(output int lat);
    lat = 0;
    while (!busy && lat < 60) begin @(negedge clk); lat++; end
  endtask

  // Walks one tick from its first INJECT cycle, recording what the core saw.
  // done_after = WAIT cycle in which core_done rises (0 = never).
  task automatic walk_tick(input int done_after);
    obs_seq_err = 0;
    for (int k = 0; k < NP; k++) begin
      obs_tok[k] = core_bus.core_tokens_in;
      if (core_bus.core_processor_id !== PW'(k) || core_bus.core_hold !== 1'b0 ||
          core_bus.core_clock_slow !== 1'b0 || busy !== 1'b1) obs_seq_err++;
      @(negedge clk);
    end
    obs_slow     = core_bus.core_clock_slow;
    obs_tok_tock = core_bus.core_tokens_in;
    @(negedge clk);
    obs_wait = 0;
    while (core_bus.core_hold === 1'b0 && obs_wait < 400) begin
      obs_wait++;
      core_bus.core_done = (done_after > 0) && (obs_wait >= done_after);
      @(negedge clk);
    end
    core_bus.core_done = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (core_bus.core_processor_id !== PW'(k) || core_bus.core_hold !== 1'b1 ||
          busy !== 1'b1) obs_seq_err++;
      @(negedge clk);
    end
    obs_idle_after = !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (core_bus.core_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %0b expected 1", core_bus.core_hold); end
    n_checks++; if (core_bus.core_clock_slow !== 1'b0) begin n_fail++; $display("FAIL reset_slow: got %0b expected 0", core_bus.core_clock_slow); end
    n_checks++; if (core_bus.core_tokens_in !== 8'h00) begin n_fail++; $display("FAIL reset_tokens: got %0h expected 0", core_bus.core_tokens_in); end
    n_checks++; if (core_bus.core_processor_id !== 4'd0) begin n_fail++; $display("FAIL reset_pid: got %0d expected 0", core_bus.core_processor_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if ({overrun, timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %0b expected 00", {overrun, timeout}); end
    n_checks++; if (rd_data !== 2'b00) begin n_fail++; $display("FAIL reset_rd: got %0b expected 00", rd_data); end
    n_checks++; if (tick_count !== 8'd0 || evt_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", tick_count, evt_count); end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || core_bus.core_hold !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got busy=%0b hold=%0b expected 0/1", busy, core_bus.core_hold); end
  endtask

  task automatic test_injection();
    int lat;
    for (int i = 0; i < 8; i++) write_inj($urandom_range(15, 0), TW'($urandom));
    write_inj(2, 8'h05);
    write_inj(9, 8'h0A);
    write_inj(12, 8'hEE);
    randomize_resp();
    for (int pass = 0; pass < 2; pass++) begin
      pulse_step();
      wait_busy(lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL inj_pickup_lat: got %0d expected 1", lat); end
      walk_tick(1);
      n_checks++; if (obs_seq_err !== 0) begin n_fail++; $display("FAIL inj_sequence: got %0d errors expected 0", obs_seq_err); end
      for (int k = 0; k < NP; k++) begin
        n_checks++;
        if (obs_tok[k] !== inj_m[k]) begin n_fail++; $display("FAIL inj_tokens pid %0d pass %0d: got %0h expected %0h", k, pass, obs_tok[k], inj_m[k]); end
      end
      n_checks++; if (obs_slow !== 1'b1 || obs_tok_tock !== 8'h00) begin n_fail++; $display("FAIL inj_tock: got slow=%0b tok=%0h expected 1/0", obs_slow, obs_tok_tock); end
      n_checks++; if (obs_wait !== 1) begin n_fail++; $display("FAIL inj_wait: got %0d expected 1", obs_wait); end
      n_checks++; if (obs_idle_after !== 1'b1) begin n_fail++; $display("FAIL inj_idle_after: got %0b expected 1", obs_idle_after); end
      model_tick();
      n_checks++; if (tick_count !== 8'(tick_m)) begin n_fail++; $display("FAIL inj_tick_count: got %0d expected %0d", tick_count, tick_m); end
    end
  endtask

  task automatic test_collect();
    int lat, d;
    logic [1:0] exp;
    randomize_resp();
    resp_tab[4] = 2'b01;
    resp_tab[7] = 2'b10;
    d = $urandom_range(6, 1);
    pulse_step();
    wait_busy(lat);
    walk_tick(d);
    n_checks++; if (obs_wait !== d || obs_seq_err !== 0) begin n_fail++; $display("FAIL col_wait: got %0d/%0d expected %0d/0", obs_wait, obs_seq_err, d); end
    model_tick();
    for (int a = 0; a < 16; a++) begin
      rd_addr = PW'(a);
      @(negedge clk);
      exp = (a < NP) ? ss_m[a] : 2'b00;
      n_checks++;
      if (rd_data !== exp) begin n_fail++; $display("FAIL col_read addr %0d: got %0b expected %0b", a, rd_data, exp); end
    end
    n_checks++; if (tick_count !== 8'(tick_m)) begin n_fail++; $display("FAIL col_tick_count: got %0d expected %0d", tick_count, tick_m); end
    n_checks++; if (evt_count !== 16'(evt_exp())) begin n_fail++; $display("FAIL col_evt_count: got %0d expected %0d", evt_count, evt_exp()); end
  endtask

  task automatic test_watchdog();
    int lat;
    randomize_resp();
    pulse_step();
    wait_busy(lat);
    walk_tick(0);
    n_checks++; if (obs_wait !== 255) begin n_fail++; $display("FAIL wd_wait: got %0d expected 255", obs_wait); end
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout: got %0b expected 1", timeout); end
    n_checks++; if (obs_seq_err !== 0 || obs_idle_after !== 1'b1) begin n_fail++; $display("FAIL wd_collect: got %0d errs idle=%0b expected 0/1", obs_seq_err, obs_idle_after); end
    model_tick();
    n_checks++; if (tick_count !== 8'(tick_m)) begin n_fail++; $display("FAIL wd_tick_count: got %0d expected %0d", tick_count, tick_m); end
    n_checks++; if (evt_count !== 16'(evt_exp())) begin n_fail++; $display("FAIL wd_evt_count: got %0d expected %0d", evt_count, evt_exp()); end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    evt_m = 0;
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got %0b expected 0", timeout); end
  endtask

  task automatic test_divider();
    int lat, span, gap, guard;
    randomize_resp();
    core_bus.core_done = 1'b1;
    div_value = 8'd3;
    run_en = 1'b1;
    wait_busy(lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL div_first_pickup: got %0d expected 5", lat); end
    for (int t = 0; t < 2; t++) begin
      span = 0; gap = 0;
      while (busy && span < 100) begin span++; @(negedge clk); end
      while (!busy && gap < 100) begin gap++; @(negedge clk); end
      n_checks++; if (span !== 22) begin n_fail++; $display("FAIL div_busy_span %0d: got %0d expected 22", t, span); end
      n_checks++; if (gap !== 1) begin n_fail++; $display("FAIL div_idle_gap %0d: got %0d expected 1", t, gap); end
    end
    run_en = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin guard++; @(negedge clk); end
    repeat (3) @(negedge clk);
    repeat (3) model_tick();
    n_checks++; if (busy !== 1'b0 || tick_count !== 8'(tick_m)) begin n_fail++; $display("FAIL div_ticks: got busy=%0b count=%0d expected 0/%0d", busy, tick_count, tick_m); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL div_overrun: got %0b expected 1", overrun); end
    n_checks++; if (evt_count !== 16'(evt_exp())) begin n_fail++; $display("FAIL div_evt_count: got %0d expected %0d", evt_count, evt_exp()); end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    evt_m = 0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL div_clr: got %0b expected 0", overrun); end
    // Second step lands while the first is still pending; its overrun beats clr.
    step = 1'b1;
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    step = 1'b0;
    clr_flags = 1'b0;
    evt_m = 0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL div_set_wins: got %0b expected 1", overrun); end
    repeat (60) @(negedge clk);
    repeat (2) model_tick();
    n_checks++; if (busy !== 1'b0 || tick_count !== 8'(tick_m)) begin n_fail++; $display("FAIL div_step_ticks: got busy=%0b count=%0d expected 0/%0d", busy, tick_count, tick_m); end
    n_checks++; if (evt_count !== 16'(evt_exp())) begin n_fail++; $display("FAIL div_step_evt: got %0d expected %0d", evt_count, evt_exp()); end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    evt_m = 0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL div_clr2: got %0b expected 0", overrun); end
    core_bus.core_done = 1'b0;
  endtask

  task automatic test_midreset();
    int lat;
    pulse_step();
    repeat (15) @(negedge clk);
    write_inj(3, 8'h77);
    n_checks++; if (busy !== 1'b1 || core_bus.core_hold !== 1'b0 || core_bus.core_clock_slow !== 1'b0) begin n_fail++; $display("FAIL mr_in_wait: got busy=%0b hold=%0b expected 1/0", busy, core_bus.core_hold); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_checks++; if (busy !== 1'b0 || core_bus.core_hold !== 1'b1 || core_bus.core_clock_slow !== 1'b0) begin n_fail++; $display("FAIL mr_abort: got busy=%0b hold=%0b slow=%0b expected 0/1/0", busy, core_bus.core_hold, core_bus.core_clock_slow); end
    n_checks++; if (tick_count !== 8'd0 || timeout !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL mr_state: got count=%0d to=%0b ov=%0b expected 0/0/0", tick_count, timeout, overrun); end
    for (int a = 0; a < NP; a++) begin
      rd_addr = PW'(a);
      @(negedge clk);
      n_checks++;
      if (rd_data !== 2'b00) begin n_fail++; $display("FAIL mr_ss_cleared addr %0d: got %0b expected 00", a, rd_data); end
    end
    randomize_resp();
    resp_tab[0] = 2'b01; resp_tab[5] = 2'b11; resp_tab[8] = 2'b01;
    pulse_step();
    wait_busy(lat);
    walk_tick(2);
    for (int k = 0; k < NP; k++) begin
      n_checks++;
      if (obs_tok[k] !== inj_m[k]) begin n_fail++; $display("FAIL mr_inj_cleared pid %0d: got %0h expected %0h", k, obs_tok[k], inj_m[k]); end
    end
    model_tick();
    n_checks++; if (tick_count !== 8'(tick_m)) begin n_fail++; $display("FAIL mr_tick_count: got %0d expected %0d", tick_count, tick_m); end
    n_checks++; if (evt_count !== 16'(evt_exp())) begin n_fail++; $display("FAIL mr_evt_count: got %0d expected %0d", evt_count, evt_exp()); end
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; step = 1'b0; div_value = '0; clr_flags = 1'b0;
    inj_we = 1'b0; inj_addr = '0; inj_data = '0; rd_addr = '0;
    core_bus.core_done = 1'b0;
    for (int i = 0; i < NP; i++) resp_tab[i] = 2'b00;
    model_reset();
    test_reset();
    test_injection();
    test_collect();
    test_watchdog();
    test_divider();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
